// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
//
// Machine-mode CSR file for the MCU core. It provides the CSR read value
// used as the CSR source on the register-file write-data path. It performs
// the mstatus/mepc/mcause updates on interrupt trap entry and on MRET. It
// exports the trap vector, the exception PC and the interrupt request. It
// also synchronises the external interrupt line.
//
// Optional feature macro: CSR_MCYCLE_EN
//   When defined, a 64-bit cycle counter is added. It is readable and
//   writable at mcycle (0xB00) / mcycleh (0xB80). It has read-only aliases
//   at cycle (0xC00) / cycleh (0xC80).
//   When undefined, those addresses read 0 and writes to them are ignored.
//
// Ports
//   clk        core clock
//   rst        synchronous, active-high reset
//   csr_we     CSR instruction write strobe (already qualified upstream)
//   csr_op     00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC
//   csr_addr   CSR address (instr[31:20])
//   csr_wd     rs1 value or zero-extended zimm
//   int_taken  control FSM enters the trap this cycle
//   mret       MRET executing this cycle
//   pc         PC saved into mepc on trap entry
//   intr       asynchronous external interrupt, level-sensitive
//   csr_rd     current (pre-write) value of the addressed CSR
//   mtvec      trap vector
//   mepc       return address
//   int_req    interrupt request to the control FSM
// ---------------------------------------------------------------------------
module csr_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  input  logic        int_taken,
  input  logic        mret,
  input  logic [31:0] pc,
  input  logic        intr,
  output logic [31:0] csr_rd,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        int_req
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [31:0] CAUSE_MEXT    = 32'h8000_000B;

  // Architectural state
  logic        mie_bit_reg;   // mstatus.MIE
  logic        mpie_bit_reg;  // mstatus.MPIE
  logic        meie_bit_reg;  // mie.MEIE
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [1:0]  intr_sync_reg; // [0] first stage, [1] synchronised level

  logic        wr_en;
  logic [31:0] op_val;

`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE   = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH  = 12'hC80;

  logic [63:0] mcycle_reg;
`endif

  // Read mux. This is purely combinational, so the cycle that performs a
  // write still sees the old value. That old value is the value returned
  // to rd.
  always_comb begin
    csr_rd = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rd = {24'h0, mpie_bit_reg, 3'b000, mie_bit_reg, 3'b000};
      ADDR_MIE:      csr_rd = {20'h0, meie_bit_reg, 11'h0};
      ADDR_MTVEC:    csr_rd = mtvec_reg;
      ADDR_MSCRATCH: csr_rd = mscratch_reg;
      ADDR_MEPC:     csr_rd = mepc_reg;
      ADDR_MCAUSE:   csr_rd = mcause_reg;
      ADDR_MIP:      csr_rd = {20'h0, intr_sync_reg[1], 11'h0};
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE,
      ADDR_CYCLE:    csr_rd = mcycle_reg[31:0];
      ADDR_MCYCLEH,
      ADDR_CYCLEH:   csr_rd = mcycle_reg[63:32];
`endif
      default:       csr_rd = 32'h0;
    endcase
  end

  // Compute the read-modify-write result from the pre-write value. Each
  // register's field mask is applied afterwards at its own update site.
  always_comb begin
    op_val = csr_rd;
    case (csr_op)
      2'b01:   op_val = csr_wd;
      2'b10:   op_val = csr_rd | csr_wd;
      2'b11:   op_val = csr_rd & ~csr_wd;
      default: op_val = csr_rd;
    endcase
  end

  // A trap or an MRET in the same cycle swallows any CSR write completely.
  assign wr_en = csr_we && (csr_op != 2'b00) && !int_taken && !mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_reg   <= 1'b0;
      mpie_bit_reg  <= 1'b0;
      meie_bit_reg  <= 1'b0;
      mtvec_reg     <= 32'h0;
      mscratch_reg  <= 32'h0;
      mepc_reg      <= 32'h0;
      mcause_reg    <= 32'h0;
      intr_sync_reg <= 2'b00;
    end else begin
      intr_sync_reg <= {intr_sync_reg[0], intr};
      if (int_taken) begin
        // Trap entry has priority over a coincident MRET.
        mepc_reg     <= pc & ~32'h3;
        mcause_reg   <= CAUSE_MEXT;
        mpie_bit_reg <= mie_bit_reg;
        mie_bit_reg  <= 1'b0;
      end else if (mret) begin
        mie_bit_reg  <= mpie_bit_reg;
        mpie_bit_reg <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie_bit_reg  <= op_val[3];
            mpie_bit_reg <= op_val[7];
          end
          ADDR_MIE:      meie_bit_reg <= op_val[11];
          ADDR_MTVEC:    mtvec_reg    <= op_val & ~32'h3;
          ADDR_MSCRATCH: mscratch_reg <= op_val;
          ADDR_MEPC:     mepc_reg     <= op_val & ~32'h3;
          ADDR_MCAUSE:   mcause_reg   <= op_val;
          default:       ;
        endcase
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  // A write to either half loads only that half. The increment is skipped
  // for the whole counter in that cycle. The cycle/cycleh aliases are
  // never write targets.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_reg <= 64'h0;
    end else if (wr_en && (csr_addr == ADDR_MCYCLE)) begin
      mcycle_reg[31:0] <= op_val;
    end else if (wr_en && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle_reg[63:32] <= op_val;
    end else begin
      mcycle_reg <= mcycle_reg + 64'd1;
    end
  end
`else
  // No counter: the counter addresses fall through to the read default of 0.
`endif

  assign mtvec   = mtvec_reg;
  assign mepc    = mepc_reg;
  assign int_req = intr_sync_reg[1] & mie_bit_reg & meie_bit_reg;

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
//
// Directed testbench for csr_unit. Inputs change on the falling edge, and
// outputs are checked after the rising edge that consumed them. Every
// comparison goes through check().
// ---------------------------------------------------------------------------
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic        int_taken;
  logic        mret;
  logic [31:0] pc;
  logic        intr;
  logic [31:0] csr_rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        int_req;

  int checks = 0;
  int errors = 0;

  csr_unit dut (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (csr_we),
    .csr_op    (csr_op),
    .csr_addr  (csr_addr),
    .csr_wd    (csr_wd),
    .int_taken (int_taken),
    .mret      (mret),
    .pc        (pc),
    .intr      (intr),
    .csr_rd    (csr_rd),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .int_req   (int_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  // Combinational read of one CSR. The write strobe is low while this runs.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] want);
    csr_addr = a;
    #1;
    check(tag, csr_rd, want);
  endtask

  // One CSR instruction. It returns on the falling edge after the write
  // edge, with the strobe already dropped.
  task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    @(negedge clk);
    csr_we   = 1'b1;
    csr_op   = op;
    csr_addr = a;
    csr_wd   = wd;
    $display("csr op=%0d addr=%03h wd=%08h", op, a, wd);
    @(negedge clk);
    csr_we = 1'b0;
    csr_op = 2'b00;
    csr_wd = 32'h0;
  endtask

  initial begin
    rst = 1'b1; csr_we = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wd = 32'h0;
    int_taken = 1'b0; mret = 1'b0; pc = 32'h0; intr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mtvec_rd", 12'h305, 32'h0);
    check("rst_mtvec", mtvec, 32'h0);
    check("rst_mepc", mepc, 32'h0);
    check("rst_int_req", {31'h0, int_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // mtvec write with low bits forced to zero; the old value is visible
    // during the write cycle.
    @(negedge clk);
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h305; csr_wd = 32'h0000_1237;
    $display("csr op=1 addr=305 wd=00001237");
    #1 check("mtvec_prewrite", csr_rd, 32'h0);
    @(negedge clk);
    csr_we = 1'b0; csr_op = 2'b00;
    rd("mtvec_rd", 12'h305, 32'h0000_1234);
    check("mtvec_out", mtvec, 32'h0000_1234);

    // Setting MEIE and clearing MIE leaves the interrupt masked.
    csr_write(2'b01, 12'h300, 32'h8);
    rd("mstatus_set", 12'h300, 32'h8);
    csr_write(2'b10, 12'h304, 32'h800);
    rd("mie_rs", 12'h304, 32'h800);
    intr = 1'b1;
    csr_write(2'b11, 12'h300, 32'h8);
    rd("mstatus_rc", 12'h300, 32'h0);
    repeat (3) @(negedge clk);
    check("req_masked", {31'h0, int_req}, 32'h0);
    rd("mip_high", 12'h344, 32'h800);

    // Synchroniser latency: the request appears two edges after intr rises.
    intr = 1'b0;
    repeat (3) @(negedge clk);
    rd("mip_low", 12'h344, 32'h0);
    csr_write(2'b10, 12'h300, 32'h8);
    intr = 1'b1;
    $display("intr rise");
    check("req_t0", {31'h0, int_req}, 32'h0);
    @(negedge clk);
    check("req_t1", {31'h0, int_req}, 32'h0);
    @(negedge clk);
    check("req_t2", {31'h0, int_req}, 32'h1);

    // Trap entry, with a coincident mscratch write that must be dropped.
    @(negedge clk);
    int_taken = 1'b1; pc = 32'h0000_0106;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wd = 32'h1111_1111;
    $display("trap pc=%08h", pc);
    @(negedge clk);
    int_taken = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
    check("trap_mepc_out", mepc, 32'h0000_0104);
    rd("trap_mepc_rd", 12'h341, 32'h0000_0104);
    rd("trap_mcause", 12'h342, 32'h8000_000B);
    rd("trap_mstatus", 12'h300, 32'h80);
    check("trap_req", {31'h0, int_req}, 32'h0);
    rd("trap_wr_dropped", 12'h340, 32'h0);

    // MRET, with a coincident mscratch write that must be dropped.
    @(negedge clk);
    mret = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wd = 32'hDEAD_BEEF;
    $display("mret");
    @(negedge clk);
    mret = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
    rd("mret_mstatus", 12'h300, 32'h88);
    rd("mret_wr_dropped", 12'h340, 32'h0);
    check("mret_req", {31'h0, int_req}, 32'h1);

    // A trap and an MRET in the same cycle: the trap wins.
    @(negedge clk);
    int_taken = 1'b1; mret = 1'b1; pc = 32'h0000_0200;
    $display("trap+mret pc=%08h", pc);
    @(negedge clk);
    int_taken = 1'b0; mret = 1'b0;
    rd("both_mstatus", 12'h300, 32'h80);
    check("both_mepc", mepc, 32'h0000_0200);

    // Field masks and the set/clear operations
    csr_write(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd("mstatus_mask", 12'h300, 32'h88);
    csr_write(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h800);
    csr_write(2'b01, 12'h341, 32'hFFFF_FFFF);
    rd("mepc_mask", 12'h341, 32'hFFFF_FFFC);
    check("mepc_out_mask", mepc, 32'hFFFF_FFFC);
    csr_write(2'b01, 12'h342, 32'h1234_5678);
    rd("mcause_full", 12'h342, 32'h1234_5678);
    csr_write(2'b01, 12'h340, 32'hA5A5_A5A5);
    rd("mscratch_rw", 12'h340, 32'hA5A5_A5A5);
    csr_write(2'b00, 12'h340, 32'h0);
    rd("op_none", 12'h340, 32'hA5A5_A5A5);
    csr_write(2'b11, 12'h305, 32'h0000_0204);
    rd("mtvec_rc", 12'h305, 32'h0000_1030);
    csr_write(2'b10, 12'h340, 32'h0F0F_0000);
    rd("mscratch_rs", 12'h340, 32'hAFAF_A5A5);
    csr_write(2'b01, 12'h344, 32'h0);
    rd("mip_ro", 12'h344, 32'h800);

    // An unimplemented address reads 0, and its write disturbs nothing.
    csr_write(2'b01, 12'h7C0, 32'hFFFF_FFFF);
    rd("unk_rd", 12'h7C0, 32'h0);
    rd("unk_mscratch", 12'h340, 32'hAFAF_A5A5);
    rd("unk_mtvec", 12'h305, 32'h0000_1030);

`ifdef CSR_MCYCLE_EN
    // Low-half load, then high-half load (no increment), then a carry.
    @(negedge clk);
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'hB00; csr_wd = 32'hFFFF_FFFE;
    $display("csr op=1 addr=b00 wd=fffffffe");
    @(negedge clk);
    csr_addr = 12'hB80; csr_wd = 32'h0;
    $display("csr op=1 addr=b80 wd=00000000");
    @(negedge clk);
    csr_we = 1'b0; csr_op = 2'b00;
    csr_addr = 12'hB00; #1 check("mcycle_load", csr_rd, 32'hFFFF_FFFE);
    @(negedge clk);
    #1 check("mcycle_inc", csr_rd, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 check("mcycle_wrap", csr_rd, 32'h0);
    csr_addr = 12'hB80; #1 check("mcycleh_carry", csr_rd, 32'h1);
    csr_addr = 12'hC80; #1 check("cycleh_alias", csr_rd, 32'h1);
`else
    csr_write(2'b01, 12'hB00, 32'h1234_5678);
    rd("no_mcycle", 12'hB00, 32'h0);
    rd("no_mcycleh", 12'hB80, 32'h0);
    rd("no_cycle", 12'hC00, 32'h0);
`endif

    // Reset asserted together with a trap and a write: reset wins.
    @(negedge clk);
    rst = 1'b1; int_taken = 1'b1; pc = 32'h0000_0300;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wd = 32'h1;
    $display("reset with trap+write");
    @(negedge clk);
    int_taken = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mstatus", 12'h300, 32'h0);
    rd("rst2_mie", 12'h304, 32'h0);
    rd("rst2_mtvec_rd", 12'h305, 32'h0);
    rd("rst2_mepc_rd", 12'h341, 32'h0);
    rd("rst2_mcause", 12'h342, 32'h0);
    rd("rst2_mip", 12'h344, 32'h0);
    check("rst2_mtvec", mtvec, 32'h0);
    check("rst2_mepc", mepc, 32'h0);
    check("rst2_req", {31'h0, int_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd("post_rst_mip", 12'h344, 32'h800);
    check("post_rst_req", {31'h0, int_req}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

- Machine-mode control/status register file for the MCU core.
- Supplies the CSR read value to the register-file write-data select path as its CSR source.
- Handles interrupt trap entry and MRET state updates.
- Exports the trap vector, exception PC, and interrupt request to the control FSM and PC select logic.
- Synchronises the external interrupt line.

## Interface
- No parameters.
- CLK  in  1  core clock.
- RST  in  1  synchronous, active-high reset.
- CSR_WE  in  1  CSR instruction write strobe. The control unit has already qualified it, including suppression for rs1/zimm = 0 on RS/RC.
- CSR_OP  in  2  operation code:
  - 00 none
  - 01 CSRRW
  - 10 CSRRS
  - 11 CSRRC
- CSR_ADDR  in  12  CSR address (instr[31:20]).
- CSR_WD  in  32  source operand (rs1 value or zero-extended zimm).
- INT_TAKEN  in  1  control FSM is entering the trap this cycle.
- MRET  in  1  MRET executing this cycle.
- PC  in  32  PC to save in mepc on trap entry.
- INTR  in  1  asynchronous external interrupt, level-sensitive.
- CSR_RD  out  32  current value of the addressed CSR (pre-write). Feeds the register-file write-data select.
- MTVEC  out  32  trap vector.
- MEPC  out  32  return address.
- INT_REQ  out  1  interrupt request to the control FSM.

## Operation
Implemented registers; any unlisted address reads 0, and writes to it are ignored:
- mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; all other bits read 0.
- mie 0x304: MEIE bit 11 is writable; all other bits read 0.
- mtvec 0x305: bits [1:0] are forced to 0 on write (direct mode only).
- mscratch 0x340: full 32 bits.
- mepc 0x341: bits [1:0] are forced to 0 on write.
- mcause 0x342: full 32-bit write.
- mip 0x344: read-only; bit 11 = synchronised INTR. Writes are ignored.

Write value rules:
- RW: new = CSR_WD.
- RS: new = old | CSR_WD.
- RC: new = old & ~CSR_WD.
- CSR_OP = 00 never writes, even when CSR_WE = 1.
- Field masks are applied after the operation.

Trap entry (INT_TAKEN = 1):
- mepc <= PC & ~3
- mcause <= 0x8000000B
- MPIE <= MIE
- MIE <= 0

MRET:
- MIE <= MPIE
- MPIE <= 1

Priority per edge: RST > INT_TAKEN > MRET > CSR write.
- A CSR write in the same cycle as INT_TAKEN or MRET is dropped entirely, including writes to registers the trap does not touch.
- INT_TAKEN together with MRET: the trap wins and MRET is ignored.

Interrupt path:
- INTR passes through a 2-flop synchroniser.
- INT_REQ = intr_sync & MIE & MEIE, combinational from registers.

## Timing
- CSR_RD is combinational from CSR_ADDR and register state; it returns the old value in the cycle of a write.
- All state updates occur on the CLK rising edge and are visible the following cycle.
- INTR rising edge -> mip bit 11 and INT_REQ assert 2 CLK edges later (if enabled). Deassertion has the same latency.
- MTVEC and MEPC are direct register outputs (0-cycle).
- Reset: every register, the synchroniser flops, and the mcycle counter clear to 0. While RST is held, CSR_RD = 0 for every address, MTVEC = 0, MEPC = 0, INT_REQ = 0.
- RST asserted in the same cycle as INT_TAKEN, MRET or a write: reset wins and nothing is saved.

## Configuration
- CSR_MCYCLE_EN defined:
  - Adds a 64-bit cycle counter.
  - Read/write at mcycle 0xB00 (low half) and mcycleh 0xB80 (high half).
  - Read-only aliases at cycle 0xC00 and cycleh 0xC80.
  - Increments by 1 every cycle with carry into the high half; wraps from 0xFFFFFFFF_FFFFFFFF to 0.
  - A write to either half loads that half with the written value and suppresses the increment for the whole counter that cycle; the other half is held.
  - Writes to 0xC00/0xC80 are ignored.
- CSR_MCYCLE_EN undefined: no counter logic. All four addresses read 0, and writes to them are ignored.

## Test plan
- Reset, then CSRRW 0x305 with WD = 0x00001237 -> next cycle CSR_RD(0x305) = 0x00001234 and MTVEC = 0x00001234.
- With mstatus = 0x8, issue CSRRS 0x304 WD = 0x800 then CSRRC 0x300 WD = 0x8 -> mie = 0x800, mstatus = 0, and INT_REQ stays 0 with INTR = 1.
- MIE = 1, MEIE = 1, raise INTR at cycle t -> INT_REQ = 1 from cycle t+2. Then INT_TAKEN with PC = 0x00000104 -> mepc = 0x104, mcause = 0x8000000B, mstatus = 0x80, INT_REQ = 0.
- MRET after the previous case -> mstatus = 0x88. Same cycle, CSRRW 0x340 WD = 0xDEADBEEF -> mscratch unchanged (write dropped).
- CSRRW to unknown address 0x7C0 WD = 0xFFFFFFFF -> CSR_RD(0x7C0) = 0, no other register changes. Assert RST mid-sequence -> all CSRs read 0 next cycle.
- CSR_MCYCLE_EN only: write mcycle = 0xFFFFFFFE, mcycleh = 0 -> two cycles later mcycle = 0, mcycleh = 1. Without the macro, 0xB00 reads 0.
